// File: rtl/poly_voice_allocator_pkg.sv
// Shared widths, steal-mode constants and the mixer state type for the
// polyphonic voice allocator.
package poly_pkg;

    localparam int DEF_NUM_VOICES = 4;
    localparam int DEF_NOTE_W     = 6;
    localparam int DEF_DUR_W      = 6;
    localparam int DEF_SAMPLE_W   = 18;
    localparam int DEF_AGE_W      = 3;

    // Behaviour when a note arrives and every voice is busy.
    localparam int STEAL_DROP   = 0;
    localparam int STEAL_OLDEST = 1;

    typedef enum logic {
        MIX_IDLE    = 1'b0,
        MIX_COLLECT = 1'b1
    } mix_state_t;

endpackage

// File: rtl/poly_voice_allocator_if.sv
// Note-load handshake between the song reader and the allocator, plus the
// shared load bus the allocator drives towards the note_player instances.
interface poly_voice_allocator_if
    import poly_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int NOTE_W     = DEF_NOTE_W,
    parameter int DUR_W      = DEF_DUR_W
);

    logic                  load_new_note;
    logic [NOTE_W-1:0]     note_to_load;
    logic [DUR_W-1:0]      duration;
    logic [NUM_VOICES-1:0] voice_load;
    logic [NOTE_W-1:0]     voice_note;
    logic [DUR_W-1:0]      voice_duration;
    logic                  note_dropped;

    // Song reader side: offers notes, sees where they went.
    modport master (
        output load_new_note, note_to_load, duration,
        input  voice_load, voice_note, voice_duration, note_dropped
    );

    // Allocator side.
    modport slave (
        input  load_new_note, note_to_load, duration,
        output voice_load, voice_note, voice_duration, note_dropped
    );

endinterface

// File: rtl/poly_voice_allocator_voice_slot.sv
// One voice: remaining duration in beats and a saturating age that counts
// how many allocations have happened since this voice was last loaded.
module voice_slot
    import poly_pkg::*;
#(
    parameter int DUR_W = DEF_DUR_W,
    parameter int AGE_W = DEF_AGE_W
)(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             dec,
    input  logic             age_inc,
    input  logic [DUR_W-1:0] duration,
    output logic             active,
    output logic [AGE_W-1:0] age
);

    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    logic [DUR_W-1:0] count;

    assign active = (count != '0);

    // Load wins over countdown; otherwise count down on beats and grow older
    // whenever another voice is allocated while this one is sounding.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every slot sees pre-edge values.
            count <= '0;
            age   <= '0;
        end else if (load) begin
            count <= duration;
            age   <= '0;
        end else begin
            if (dec && active) begin
                count <= count - 1'b1;
            end
            if (age_inc && active && (age != AGE_MAX)) begin
                age <= age + 1'b1;
            end
        end
    end

endmodule

// File: rtl/poly_voice_allocator.sv
// N-voice allocator: assigns incoming notes to free voices (or steals the
// oldest), strobes the matching note_player, and mixes the voice samples
// with saturation once every sounding voice has delivered a sample.
module poly_voice_allocator
    import poly_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int NOTE_W     = DEF_NOTE_W,
    parameter int DUR_W      = DEF_DUR_W,
    parameter int SAMPLE_W   = DEF_SAMPLE_W,
    parameter int AGE_W      = DEF_AGE_W,
    parameter int STEAL_MODE = STEAL_DROP
)(
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           play_enable,
    input  logic                           beat,
    input  logic                           generate_next_sample,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
    input  logic [NUM_VOICES-1:0]          voice_ready,
    poly_voice_allocator_if.slave          note_bus,
    output logic [NUM_VOICES-1:0]          voice_active,
    output logic                           all_done,
    output logic [SAMPLE_W-1:0]            mix_sample,
    output logic                           mix_ready
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int SUM_W = SAMPLE_W + $clog2(NUM_VOICES);

    // Clamp limits expressed at the wide sum width.
    localparam logic signed [SUM_W-1:0] SUM_MAX =
        {{(SUM_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SUM_MIN =
        {{(SUM_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    logic [AGE_W-1:0]      age [NUM_VOICES];
    logic                  load_req;
    logic                  dec;
    logic                  any_free;
    logic [IDX_W-1:0]      free_idx;
    logic [IDX_W-1:0]      oldest_idx;
    logic [AGE_W-1:0]      oldest_age;
    logic [IDX_W-1:0]      target;
    logic                  alloc_en;
    logic                  drop;
    logic [NUM_VOICES-1:0] load_vec;
    logic [NUM_VOICES-1:0] age_inc;

    mix_state_t            state_q, state_d;
    logic [NUM_VOICES-1:0] sticky_q, sticky_d;
    logic [NUM_VOICES-1:0] seen;
    logic                  mix_fire;
    logic signed [SUM_W-1:0] sum;
    logic [SAMPLE_W-1:0]   sat;

    assign load_req = note_bus.load_new_note & play_enable;
    assign dec      = beat & play_enable;
    assign all_done = ~|voice_active;
    assign age_inc  = alloc_en ? ~load_vec : '0;

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
        voice_slot #(
            .DUR_W (DUR_W),
            .AGE_W (AGE_W)
        ) u_slot (
            .clk      (clk),
            .reset_n  (reset_n),
            .load     (load_vec[i]),
            .dec      (dec),
            .age_inc  (age_inc[i]),
            .duration (note_bus.duration),
            .active   (voice_active[i]),
            .age      (age[i])
        );
    end

    // Lowest-index free voice, and the oldest voice (strict compare keeps the lowest index on ties).
    always_comb begin
        // NOTE: every variable of a combinational block gets a default first, so no latch is inferred.
        any_free   = 1'b0;
        free_idx   = '0;
        oldest_idx = '0;
        oldest_age = age[0];
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (!voice_active[i]) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (age[i] > oldest_age) begin
                oldest_age = age[i];
                oldest_idx = IDX_W'(i);
            end
        end
    end

    // Decide whether the offered note is placed, stolen into the oldest voice, or dropped.
    always_comb begin
        alloc_en = 1'b0;
        drop     = 1'b0;
        target   = '0;
        if (load_req) begin
            if (note_bus.duration == '0) begin
                drop = 1'b1;
            end else if (any_free) begin
                alloc_en = 1'b1;
                target   = free_idx;
            end else if (STEAL_MODE == STEAL_OLDEST) begin
                alloc_en = 1'b1;
                target   = oldest_idx;
            end else begin
                drop = 1'b1;
            end
        end
        load_vec = alloc_en ? (NUM_VOICES'(1) << target) : '0;
    end

    // Register the load strobe together with the note and duration it carries.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            note_bus.voice_load     <= '0;
            note_bus.voice_note     <= '0;
            note_bus.voice_duration <= '0;
            note_bus.note_dropped   <= 1'b0;
        end else begin
            note_bus.voice_load   <= load_vec;
            note_bus.note_dropped <= drop;
            if (alloc_en) begin
                note_bus.voice_note     <= note_bus.note_to_load;
                note_bus.voice_duration <= note_bus.duration;
            end
        end
    end

    // Sign-extended sum of the sounding voices, clamped back to the sample range.
    always_comb begin
        logic [SAMPLE_W-1:0] smp;
        sum = '0;
        smp = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            smp = voice_sample[i*SAMPLE_W +: SAMPLE_W];
            if (voice_active[i]) begin
                sum = sum + $signed({{(SUM_W-SAMPLE_W){smp[SAMPLE_W-1]}}, smp});
            end
        end
        if (sum > SUM_MAX) begin
            sat = SUM_MAX[SAMPLE_W-1:0];
        end else if (sum < SUM_MIN) begin
            sat = SUM_MIN[SAMPLE_W-1:0];
        end else begin
            sat = sum[SAMPLE_W-1:0];
        end
    end

    // Mixer state and per-voice ready flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= MIX_IDLE;
            sticky_q <= '0;
        end else begin
            state_q  <= state_d;
            sticky_q <= sticky_d;
        end
    end

    // A round finishes once every sounding voice has reported; ended voices stop blocking.
    always_comb begin
        state_d  = state_q;
        sticky_d = sticky_q;
        mix_fire = 1'b0;
        seen     = sticky_q | voice_ready;
        case (state_q)
            MIX_IDLE: begin
                if (generate_next_sample) begin
                    sticky_d = '0;
                    state_d  = MIX_COLLECT;
                end
            end
            MIX_COLLECT: begin
                if (generate_next_sample) begin
                    sticky_d = '0;
                end else begin
                    sticky_d = seen;
                    if (&(seen | ~voice_active)) begin
                        mix_fire = 1'b1;
                        state_d  = MIX_IDLE;
                    end
                end
            end
            default: state_d = MIX_IDLE;
        endcase
    end

    // Capture the mix and pulse mix_ready for one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mix_sample <= '0;
            mix_ready  <= 1'b0;
        end else begin
            mix_ready <= mix_fire;
            if (mix_fire) begin
                mix_sample <= sat;
            end
        end
    end

endmodule

// File: tb/tb_poly_voice_allocator.sv
// Directed bench: one allocator per steal mode driven by identical stimulus.
module tb_poly_voice_allocator;
    import poly_pkg::*;

    localparam int NV = 4;
    localparam int NW = 6;
    localparam int DW = 6;
    localparam int SW = 18;
    localparam int AW = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             play_enable;
    logic             beat;
    logic             generate_next_sample;
    logic [NV*SW-1:0] voice_sample;
    logic [NV-1:0]    voice_ready;
    logic             load_new_note;
    logic [NW-1:0]    note_to_load;
    logic [DW-1:0]    duration;

    logic [NV-1:0]    voice_active0, voice_active1;
    logic             all_done0, all_done1;
    logic [SW-1:0]    mix_sample0, mix_sample1;
    logic             mix_ready0, mix_ready1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    poly_voice_allocator_if #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW)) bus0 ();
    poly_voice_allocator_if #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW)) bus1 ();

    assign bus0.load_new_note = load_new_note;
    assign bus0.note_to_load  = note_to_load;
    assign bus0.duration      = duration;
    assign bus1.load_new_note = load_new_note;
    assign bus1.note_to_load  = note_to_load;
    assign bus1.duration      = duration;

    poly_voice_allocator #(
        .NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW), .SAMPLE_W(SW), .AGE_W(AW),
        .STEAL_MODE(STEAL_DROP)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .play_enable(play_enable), .beat(beat),
        .generate_next_sample(generate_next_sample), .voice_sample(voice_sample),
        .voice_ready(voice_ready), .note_bus(bus0), .voice_active(voice_active0),
        .all_done(all_done0), .mix_sample(mix_sample0), .mix_ready(mix_ready0)
    );

    poly_voice_allocator #(
        .NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW), .SAMPLE_W(SW), .AGE_W(AW),
        .STEAL_MODE(STEAL_OLDEST)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .play_enable(play_enable), .beat(beat),
        .generate_next_sample(generate_next_sample), .voice_sample(voice_sample),
        .voice_ready(voice_ready), .note_bus(bus1), .voice_active(voice_active1),
        .all_done(all_done1), .mix_sample(mix_sample1), .mix_ready(mix_ready1)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic do_load(input logic [DW-1:0] d, input logic [NW-1:0] n);
        load_new_note = 1'b1;
        duration      = d;
        note_to_load  = n;
        tick();
        load_new_note = 1'b0;
    endtask

    task automatic do_beat();
        beat = 1'b1;
        tick();
        beat = 1'b0;
    endtask

    task automatic request();
        generate_next_sample = 1'b1;
        tick();
        generate_next_sample = 1'b0;
    endtask

    task automatic pulse_ready(input logic [NV-1:0] mask);
        voice_ready = mask;
        tick();
        voice_ready = '0;
    endtask

    task automatic set_sample(input int i, input logic [SW-1:0] v);
        voice_sample[i*SW +: SW] = v;
    endtask

    task automatic wait_mix(input string tag, input logic [SW-1:0] expected);
        int n = 0;
        while (mix_ready1 !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_rdy"}, 32'(mix_ready1), 1);
        check(tag, 32'(mix_sample1), 32'(expected));
        check({tag, "_dut0"}, 32'(mix_sample0), 32'(expected));
        tick();
        check({tag, "_pulse"}, 32'(mix_ready1), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n              = 1'b0;
        play_enable          = 1'b0;
        beat                 = 1'b0;
        generate_next_sample = 1'b0;
        voice_sample         = '0;
        voice_ready          = '0;
        load_new_note        = 1'b0;
        note_to_load         = '0;
        duration             = '0;
        #12;
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Reset state.
        check("rst_vload", 32'(bus1.voice_load), 0);
        check("rst_vnote", 32'(bus1.voice_note), 0);
        check("rst_vdur", 32'(bus1.voice_duration), 0);
        check("rst_active", 32'(voice_active1), 0);
        check("rst_drop", 32'(bus1.note_dropped), 0);
        check("rst_done", 32'(all_done1), 1);
        check("rst_mix", 32'(mix_sample1), 0);
        check("rst_mixrdy", 32'(mix_ready1), 0);

        // Three loads onto an idle block.
        play_enable = 1'b1;
        do_load(6'd4, 6'd10);
        check("l1_vload", 32'(bus1.voice_load), 32'h1);
        check("l1_vnote", 32'(bus1.voice_note), 10);
        check("l1_vdur", 32'(bus1.voice_duration), 4);
        check("l1_done", 32'(all_done1), 0);
        do_load(6'd5, 6'd11);
        check("l2_vload", 32'(bus1.voice_load), 32'h2);
        do_load(6'd6, 6'd12);
        check("l3_vload", 32'(bus1.voice_load), 32'h4);
        check("l3_vdur", 32'(bus1.voice_duration), 6);
        tick();
        check("l3_strobe_end", 32'(bus1.voice_load), 0);
        check("l3_active", 32'(voice_active1), 32'h7);
        do_load(6'd0, 6'd13);
        check("dur0_drop", 32'(bus1.note_dropped), 1);
        check("dur0_vload", 32'(bus1.voice_load), 0);
        check("dur0_active", 32'(voice_active1), 32'h7);
        tick();
        check("dur0_drop_end", 32'(bus1.note_dropped), 0);
        play_enable = 1'b0;
        do_load(6'd3, 6'd14);
        check("pe0_vload", 32'(bus1.voice_load), 0);
        check("pe0_drop", 32'(bus1.note_dropped), 0);
        check("pe0_active", 32'(voice_active1), 32'h7);
        play_enable = 1'b1;
        do_reset();

        // Fill all voices with ages {3,1,2,0}.
        do_load(6'd1, 6'd1);
        do_load(6'd2, 6'd2);
        do_beat();
        do_load(6'd20, 6'd3);
        check("fill_c_vload", 32'(bus1.voice_load), 32'h1);
        do_load(6'd20, 6'd4);
        check("fill_d_vload", 32'(bus1.voice_load), 32'h4);
        do_beat();
        do_load(6'd20, 6'd5);
        check("fill_e_vload", 32'(bus1.voice_load), 32'h2);
        do_load(6'd20, 6'd6);
        check("fill_f_vload", 32'(bus1.voice_load), 32'h8);
        check("fill_active0", 32'(voice_active0), 32'hF);
        check("fill_active1", 32'(voice_active1), 32'hF);
        check("age0", 32'(dut1.g_slot[0].u_slot.age), 3);
        check("age1", 32'(dut1.g_slot[1].u_slot.age), 1);
        check("age2", 32'(dut1.g_slot[2].u_slot.age), 2);
        check("age3", 32'(dut1.g_slot[3].u_slot.age), 0);

        // Fifth note: drop mode rejects, steal mode takes the oldest voice.
        do_load(6'd9, 6'd40);
        check("drop_pulse", 32'(bus0.note_dropped), 1);
        check("drop_vload", 32'(bus0.voice_load), 0);
        check("drop_active", 32'(voice_active0), 32'hF);
        check("drop_cnt0", 32'(dut0.g_slot[0].u_slot.count), 19);
        check("steal_vload", 32'(bus1.voice_load), 32'h1);
        check("steal_vdur", 32'(bus1.voice_duration), 9);
        check("steal_vnote", 32'(bus1.voice_note), 40);
        check("steal_nodrop", 32'(bus1.note_dropped), 0);
        check("steal_cnt0", 32'(dut1.g_slot[0].u_slot.count), 9);
        check("steal_age0", 32'(dut1.g_slot[0].u_slot.age), 0);
        do_load(6'd11, 6'd41);
        check("steal2_vload", 32'(bus1.voice_load), 32'h4);
        check("drop2_pulse", 32'(bus0.note_dropped), 1);
        do_reset();

        // Beat and load on the same edge.
        do_load(6'd10, 6'd1);
        do_load(6'd10, 6'd2);
        do_load(6'd1, 6'd3);
        do_beat();
        check("bl_pre_active", 32'(voice_active1), 32'h3);
        beat = 1'b1;
        do_load(6'd7, 6'd21);
        beat = 1'b0;
        check("bl_vload", 32'(bus1.voice_load), 32'h4);
        check("bl_cnt2", 32'(dut1.g_slot[2].u_slot.count), 7);
        check("bl_cnt0", 32'(dut1.g_slot[0].u_slot.count), 8);
        check("bl_cnt1", 32'(dut1.g_slot[1].u_slot.count), 8);
        check("bl_cnt3", 32'(dut1.g_slot[3].u_slot.count), 0);
        play_enable = 1'b0;
        do_beat();
        check("freeze_cnt0", 32'(dut1.g_slot[0].u_slot.count), 8);
        play_enable = 1'b1;

        // Positive saturation; voice 3 is silent so its sample is ignored.
        set_sample(0, 18'h1FFFF);
        set_sample(1, 18'h1FFFF);
        set_sample(2, 18'h00000);
        set_sample(3, 18'h1FFFF);
        request();
        check("sat_pos_early0", 32'(mix_ready1), 0);
        pulse_ready(4'b0001);
        check("sat_pos_early1", 32'(mix_ready1), 0);
        pulse_ready(4'b0110);
        wait_mix("sat_pos", 18'h1FFFF);

        // Negative saturation.
        set_sample(0, 18'h20000);
        set_sample(1, 18'h20000);
        set_sample(2, 18'h3FFFF);
        request();
        pulse_ready(4'b0111);
        wait_mix("sat_neg", 18'h20000);

        // Plain signed sum, inactive voice contributes nothing.
        set_sample(0, 18'd100);
        set_sample(1, 18'h3FFE2);
        set_sample(2, 18'd5);
        set_sample(3, 18'd1000);
        request();
        pulse_ready(4'b0111);
        wait_mix("sum", 18'd75);

        // A request during collection restarts the round.
        request();
        pulse_ready(4'b0001);
        request();
        pulse_ready(4'b0110);
        check("restart_wait", 32'(mix_ready1), 0);
        pulse_ready(4'b0001);
        wait_mix("restart", 18'd75);

        // A voice that ends mid-round stops blocking and drops out of the sum.
        set_sample(0, 18'd1000);
        set_sample(1, 18'd2000);
        set_sample(2, 18'd5000);
        request();
        pulse_ready(4'b0011);
        for (int i = 0; i < 6; i++) do_beat();
        check("end_mid_wait", 32'(mix_ready1), 0);
        do_beat();
        wait_mix("end_mid", 18'd3000);
        check("end_mid_active", 32'(voice_active1), 32'h3);

        // No voices: the mix is zero one cycle after the request.
        do_beat();
        check("empty_done", 32'(all_done1), 1);
        request();
        check("empty_early", 32'(mix_ready1), 0);
        tick();
        check("empty_rdy", 32'(mix_ready1), 1);
        check("empty_mix", 32'(mix_sample1), 0);

        // Asynchronous reset mid-note while frozen.
        do_load(6'd5, 6'd9);
        check("solo_vload", 32'(bus1.voice_load), 32'h1);
        request();
        pulse_ready(4'b0001);
        wait_mix("solo", 18'd1000);
        play_enable = 1'b0;
        do_beat();
        check("frozen_active", 32'(voice_active1), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_active", 32'(voice_active1), 0);
        check("arst_done", 32'(all_done1), 1);
        check("arst_mix", 32'(mix_sample1), 0);
        check("arst_vnote", 32'(bus1.voice_note), 0);
        check("arst_vdur", 32'(bus1.voice_duration), 0);
        check("arst_cnt0", 32'(dut1.g_slot[0].u_slot.count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        request();
        tick();
        check("post_rst_rdy", 32'(mix_ready1), 1);
        check("post_rst_mix", 32'(mix_sample1), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
